rv_clint: RTL and testbench
===========================

// Module: rv_clint
// PURPOSE
//  Memory-mapped machine timer / interrupt unit for the rv32emc data bus: free-running mtime
//  counter with prescaler, NCMP independent mtimecmp channels and a software-interrupt bit.
//  Sits beside the core on the d_* bus; read data is OR-combined with RAM read data.
//  Drives the core's machine timer (mtip) and software (msip) interrupt requests.
// PARAMETERS
//  NCMP   1              number of compare channels (1..8)
//  TW     64             mtime/mtimecmp width in bits (33..64); hi words hold TW-32 bits
//  PSW    8              prescaler register width
//  BASE   32'hffff8000   base byte address of the register window
// PORTS
//  clk     in   1     clock
//  reset   in   1     synchronous reset, active-high
//  d_adr   in   32    byte address
//  d_dw    in   32    write data
//  d_we    in   4     byte write enables
//  d_re    in   1     read enable
//  d_dr    out  32    read data, 0 when not selected
//  mtip    out  1     timer irq: OR over k of (cmp_hit[k] & ien[k])
//  msip    out  1     software irq, = msip register bit 0
//  cmp_hit out  NCMP  per-channel compare status (mtime >= mtimecmp[k])
// BEHAVIOUR
//  Map (offset): 0x000 mtime lo, 0x004 mtime hi, 0x008+8k mtimecmp[k] lo, 0x00C+8k hi,
//   0x100 msip[0], 0x104 prescale[PSW-1:0], 0x108 ctrl {ien[NCMP-1:0] at [15:8], run at [0]},
//   0x10C status (cmp_hit, read-only). Unmapped offsets: read 0, writes ignored.
//  Reset: mtime=0, mtimecmp[k]=all-ones, prescale=0, run=1, ien=0, msip=0, d_dr=0,
//   cmp_hit=0, mtip=0. Reset asserted mid-access: reset values take effect at that edge.
//  Writes: honor d_we byte lanes; bits above TW-32 in hi words read 0, writes discarded.
//  Reads: d_dr registered, valid the cycle after d_re with hit; else 0 (bus is OR-merged).
//   d_re and d_we same cycle: write takes effect; read returns pre-write value.
//  Tick: prescale counter pc counts 0..prescale; tick when pc==prescale and run=1; pc then 0.
//   prescale=0 -> tick every cycle. Writing prescale or run clears pc.
//  mtime += 1 on tick; wraps from 2**TW-1 to 0 (cmp_hit drops accordingly).
//   Write to either mtime half in a tick cycle: written half takes d_dw, other half holds
//   (no increment, no carry that cycle).
//  Compare: cmp_hit[k] registered, 1 cycle after mtime/mtimecmp change; comparison is >=
//   unsigned on TW bits. mtip registered from cmp_hit & ien (2 cycles after mtime reaches cmp).
//   Writing mtimecmp[k] above mtime clears cmp_hit[k] next cycle (level irq ack).
//  msip: level, set/cleared only by software write.
// CONFIGURATION
//  RV_CLINT_SNAPSHOT_EN defined: read of mtime lo also captures mtime hi into shadow; next
//   read of mtime hi returns shadow (atomic 64-bit read with lo-then-hi order); any write to
//   mtime invalidates shadow so hi reads live. Undefined: hi reads always return live value.
// STRUCTURE
//  pkg_rv_clint: offset localparams (OFS_MTIME, OFS_CMP, OFS_MSIP, OFS_PRESC, OFS_CTRL,
//   OFS_STAT), ctrl bit positions, clint_reg_t enum for decoded register select.
//  Sub-module rv_clint_cmp: one channel (mtimecmp lo/hi regs, byte-lane write, >= compare,
//   registered hit); instantiated NCMP times in a generate loop.
// TESTING
//  reset, read 0x008 -> 0xffffffff; 0x000 -> 0; mtip=0, msip=0.
//  prescale=3, run=1: mtime lo reads advance by 1 every 4 clk; mtime=0xffffffff lo -> hi+1.
//  mtime=100, cmp[0]=105, ien[0]=1 -> cmp_hit[0] rises at mtime=105(+1 clk), mtip +2 clk;
//   write cmp[0]=200 -> mtip falls 2 clk later.
//  NCMP=2, cmp[1]=10, ien=2'b01 -> cmp_hit[1]=1 and mtip stays 0.
//  write mtime lo=0xfffffffe during tick, hi=0 -> no increment that cycle; wrap at TW=40 to 0.
//  SNAPSHOT_EN: mtime=0x0_ffffffff, read lo then hi after carry -> hi reads 0, not 1.

Source files
------------

// File: rtl/rv_clint_pkg.sv
// Shared definitions for the rv_clint timer/interrupt unit: register offsets,
// ctrl bit positions, decoded register select and a byte-lane merge helper.
package rv_clint_pkg;

    localparam logic [8:0] OFS_MTIME    = 9'h000;
    localparam logic [8:0] OFS_MTIME_HI = 9'h004;
    localparam logic [8:0] OFS_CMP      = 9'h008;
    localparam logic [8:0] OFS_MSIP     = 9'h100;
    localparam logic [8:0] OFS_PRESC    = 9'h104;
    localparam logic [8:0] OFS_CTRL     = 9'h108;
    localparam logic [8:0] OFS_STAT     = 9'h10C;

    localparam int CTRL_RUN_BIT = 0;
    localparam int CTRL_IEN_LSB = 8;

    typedef enum logic [3:0] {
        REG_NONE,
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_MSIP,
        REG_PRESC,
        REG_CTRL,
        REG_STAT
    } clint_reg_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  we);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = we[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rv_clint_cmp.sv
// One mtimecmp channel: lo/hi compare register with byte-lane writes and a
// registered unsigned mtime >= mtimecmp status.
module rv_clint_cmp
    import rv_clint_pkg::*;
#(
    parameter int TW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [TW-1:0] i_mtime,
    input  logic [3:0]    i_we_lo,
    input  logic [3:0]    i_we_hi,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_cmp_lo,
    output logic [31:0]   o_cmp_hi,
    output logic          o_hit
);

    logic [TW-1:0] r_cmp;
    logic          r_hit;
    logic [31:0]   w_hi_m;
    logic          w_unused_hi;

    // Hi word only holds TW-32 bits; anything above is dropped on write.
    assign w_hi_m      = byte_merge(32'(r_cmp[TW-1:32]), i_wdata, i_we_hi);
    assign w_unused_hi = ^w_hi_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmp <= '1;
            r_hit <= 1'b0;
        end else begin
            if (|i_we_lo) r_cmp[31:0] <= byte_merge(r_cmp[31:0], i_wdata, i_we_lo);
            if (|i_we_hi) r_cmp[TW-1:32] <= w_hi_m[TW-33:0];
            r_hit <= (i_mtime >= r_cmp);
        end
    end

    assign o_cmp_lo = r_cmp[31:0];
    assign o_cmp_hi = 32'(r_cmp[TW-1:32]);
    assign o_hit    = r_hit;

endmodule

// File: rtl/rv_clint.sv
// Machine timer / software interrupt unit on the d_* bus (mtime, NCMP compares, msip).
// Optional RV_CLINT_SNAPSHOT_EN: mtime lo read latches hi for an atomic lo-then-hi read.
module rv_clint
    import rv_clint_pkg::*;
#(
    parameter int          NCMP = 1,
    parameter int          TW   = 64,
    parameter int          PSW  = 8,
    parameter logic [31:0] BASE = 32'hffff8000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     d_adr,
    input  logic [31:0]     d_dw,
    input  logic [3:0]      d_we,
    input  logic            d_re,
    output logic [31:0]     d_dr,
    output logic            mtip,
    output logic            msip,
    output logic [NCMP-1:0] cmp_hit
);

    localparam int HW = TW - 32;

    logic [TW-1:0]  r_mtime;
    logic [PSW-1:0] r_pc;
    logic [PSW-1:0] r_presc;
    logic           r_run;
    logic [NCMP-1:0] r_ien;
    logic           r_msip;
    logic           r_mtip;
    logic [31:0]    r_dr;

    logic           w_win;
    logic [8:0]     w_wofs;
    logic [8:0]     w_cmp_rel;
    logic [2:0]     w_ch;
    clint_reg_t     w_reg;
    logic           w_wr;
    logic           w_tick;
    logic [3:0]     w_mt_lo_we;
    logic [3:0]     w_mt_hi_we;
    logic [31:0]    w_mt_hi_m;
    logic [31:0]    w_presc_m;
    logic [HW-1:0]  w_hi_rd;
    logic [31:0]    w_rdata;
    logic [NCMP-1:0] w_hit;
    logic [31:0]    w_cmp_lo [NCMP];
    logic [31:0]    w_cmp_hi [NCMP];
    logic           w_unused;

    assign w_win     = (d_adr[31:9] == BASE[31:9]);
    assign w_wofs    = {d_adr[8:2], 2'b00};
    assign w_cmp_rel = w_wofs - OFS_CMP;
    assign w_ch      = w_cmp_rel[5:3];
    assign w_wr      = |d_we;
    assign w_unused  = ^{d_adr[1:0], w_cmp_rel, w_mt_hi_m, w_presc_m};

    always_comb begin
        w_reg = REG_NONE;
        if (w_win) begin
            if (w_wofs == OFS_MTIME)                      w_reg = REG_MTIME_LO;
            else if (w_wofs == OFS_MTIME_HI)              w_reg = REG_MTIME_HI;
            else if (w_wofs >= OFS_CMP && w_wofs < OFS_CMP + 9'(8*NCMP))
                w_reg = w_wofs[2] ? REG_CMP_HI : REG_CMP_LO;
            else if (w_wofs == OFS_MSIP)                  w_reg = REG_MSIP;
            else if (w_wofs == OFS_PRESC)                 w_reg = REG_PRESC;
            else if (w_wofs == OFS_CTRL)                  w_reg = REG_CTRL;
            else if (w_wofs == OFS_STAT)                  w_reg = REG_STAT;
        end
    end

    assign w_mt_lo_we = (w_reg == REG_MTIME_LO) ? d_we : 4'h0;
    assign w_mt_hi_we = (w_reg == REG_MTIME_HI) ? d_we : 4'h0;
    assign w_mt_hi_m  = byte_merge(32'(r_mtime[TW-1:32]), d_dw, w_mt_hi_we);
    assign w_presc_m  = byte_merge(32'(r_presc), d_dw, d_we);
    assign w_tick     = r_run && (r_pc == r_presc);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
        end else if (w_wr && (w_reg == REG_PRESC || w_reg == REG_CTRL)) begin
            r_pc <= '0;
        end else if (w_tick) begin
            r_pc <= '0;
        end else if (r_run) begin
            r_pc <= r_pc + PSW'(1);
        end
    end

    // A software write to either half suppresses the increment for that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtime <= '0;
        end else if (|w_mt_lo_we) begin
            r_mtime[31:0] <= byte_merge(r_mtime[31:0], d_dw, w_mt_lo_we);
        end else if (|w_mt_hi_we) begin
            r_mtime[TW-1:32] <= w_mt_hi_m[HW-1:0];
        end else if (w_tick) begin
            r_mtime <= r_mtime + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_run   <= 1'b1;
            r_ien   <= '0;
            r_msip  <= 1'b0;
        end else begin
            if (w_wr && w_reg == REG_PRESC) r_presc <= w_presc_m[PSW-1:0];
            if (w_reg == REG_CTRL && d_we[0]) r_run <= d_dw[CTRL_RUN_BIT];
            if (w_reg == REG_CTRL && d_we[1]) r_ien <= d_dw[CTRL_IEN_LSB +: NCMP];
            if (w_reg == REG_MSIP && d_we[0]) r_msip <= d_dw[0];
        end
    end

    for (genvar k = 0; k < NCMP; k++) begin : g_cmp
        logic [3:0] w_we_lo;
        logic [3:0] w_we_hi;
        assign w_we_lo = (w_reg == REG_CMP_LO && w_ch == 3'(k)) ? d_we : 4'h0;
        assign w_we_hi = (w_reg == REG_CMP_HI && w_ch == 3'(k)) ? d_we : 4'h0;

        rv_clint_cmp #(.TW(TW)) u_cmp (
            .clk      (clk),
            .reset    (reset),
            .i_mtime  (r_mtime),
            .i_we_lo  (w_we_lo),
            .i_we_hi  (w_we_hi),
            .i_wdata  (d_dw),
            .o_cmp_lo (w_cmp_lo[k]),
            .o_cmp_hi (w_cmp_hi[k]),
            .o_hit    (w_hit[k])
        );
    end

`ifdef RV_CLINT_SNAPSHOT_EN
    logic [HW-1:0] r_shadow;
    logic          r_shadow_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow     <= '0;
            r_shadow_vld <= 1'b0;
        end else if ((|w_mt_lo_we) || (|w_mt_hi_we)) begin
            r_shadow_vld <= 1'b0;
        end else if (d_re && w_reg == REG_MTIME_LO) begin
            r_shadow     <= r_mtime[TW-1:32];
            r_shadow_vld <= 1'b1;
        end else if (d_re && w_reg == REG_MTIME_HI) begin
            r_shadow_vld <= 1'b0;
        end
    end

    assign w_hi_rd = r_shadow_vld ? r_shadow : r_mtime[TW-1:32];
`else
    assign w_hi_rd = r_mtime[TW-1:32];
`endif

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_MTIME_LO: w_rdata = r_mtime[31:0];
            REG_MTIME_HI: w_rdata = 32'(w_hi_rd);
            REG_CMP_LO, REG_CMP_HI: begin
                for (int k = 0; k < NCMP; k++) begin
                    if (w_ch == 3'(k)) w_rdata = (w_reg == REG_CMP_LO) ? w_cmp_lo[k] : w_cmp_hi[k];
                end
            end
            REG_MSIP:  w_rdata = {31'h0, r_msip};
            REG_PRESC: w_rdata = 32'(r_presc);
            REG_CTRL: begin
                w_rdata[CTRL_IEN_LSB +: NCMP] = r_ien;
                w_rdata[CTRL_RUN_BIT]         = r_run;
            end
            REG_STAT:  w_rdata = 32'(w_hit);
            default:   w_rdata = '0;
        endcase
    end

    // Read data is forced to 0 when idle so the bus can be OR-merged with RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dr   <= '0;
            r_mtip <= 1'b0;
        end else begin
            r_dr   <= d_re ? w_rdata : 32'h0;
            r_mtip <= |(w_hit & r_ien);
        end
    end

    assign d_dr    = r_dr;
    assign mtip    = r_mtip;
    assign msip    = r_msip;
    assign cmp_hit = w_hit;

endmodule

// File: tb/tb_rv_clint.sv
// Directed bench for rv_clint (NCMP=2, TW=40): register table plus timing sequences.
module tb_rv_clint;

    localparam logic [31:0] B = 32'hffff8000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d_adr;
    logic [31:0] d_dw;
    logic [3:0]  d_we;
    logic        d_re;
    logic [31:0] d_dr;
    logic        mtip;
    logic        msip;
    logic [1:0]  cmp_hit;

    int n_tests = 0;
    int n_fail  = 0;

    rv_clint #(.NCMP(2), .TW(40), .PSW(8), .BASE(B)) dut (
        .clk     (clk),
        .reset   (reset),
        .d_adr   (d_adr),
        .d_dw    (d_dw),
        .d_we    (d_we),
        .d_re    (d_re),
        .d_dr    (d_dr),
        .mtip    (mtip),
        .msip    (msip),
        .cmp_hit (cmp_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dw;
        logic [3:0]  we;
        logic        re;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [31:0] adr, input logic [31:0] dw,
                                input logic [3:0] we, input logic re, input logic [31:0] exp);
        vec_t v;
        v.adr = adr; v.dw = dw; v.we = we; v.re = re; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One bus cycle: drive at negedge, sample the registered read data just after the edge.
    task automatic op(input logic [31:0] adr, input logic [31:0] dw, input logic [3:0] we,
                      input logic re, output logic [31:0] rd);
        @(negedge clk);
        d_adr = adr; d_dw = dw; d_we = we; d_re = re;
        @(posedge clk);
        #1;
        rd = d_dr;
        d_adr = 32'h0; d_dw = 32'h0; d_we = 4'h0; d_re = 1'b0;
    endtask

    task automatic wr(input logic [31:0] ofs, input logic [31:0] dw);
        logic [31:0] rd;
        op(B + ofs, dw, 4'hf, 1'b0, rd);
    endtask

    logic [31:0] rd;
    logic [31:0] exp_hi;

    initial begin
        reset = 1'b1;
        d_adr = 32'h0; d_dw = 32'h0; d_we = 4'h0; d_re = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset d_dr", d_dr, 32'h0);
        chk("reset mtip", {31'h0, mtip}, 32'h0);
        chk("reset msip", {31'h0, msip}, 32'h0);
        chk("reset cmp_hit", {30'h0, cmp_hit}, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        d_adr = B; d_re = 1'b1;
        @(posedge clk);
        #1;
        chk("reset mtime lo", d_dr, 32'h0);
        d_re = 1'b0;
        op(B + 32'h008, 0, 4'h0, 1'b1, rd);
        chk("reset cmp0 lo", rd, 32'hffffffff);
        op(B + 32'h108, 0, 4'h0, 1'b1, rd);
        chk("reset ctrl", rd, 32'h00000001);

        // Register table with the timer stopped
        tbl.push_back(mk(B + 32'h108, 32'h0,        4'hf, 1'b0, 32'h0));
        tbl.push_back(mk(B + 32'h000, 32'h12345678, 4'hf, 1'b0, 32'h0));
        tbl.push_back(mk(B + 32'h000, 32'h0,        4'h0, 1'b1, 32'h12345678));
        tbl.push_back(mk(B + 32'h004, 32'hffffffff, 4'hf, 1'b0, 32'h0));
        tbl.push_back(mk(B + 32'h004, 32'h0,        4'h0, 1'b1, 32'h000000ff));
        tbl.push_back(mk(B + 32'h000, 32'haabbccdd, 4'h2, 1'b0, 32'h0));
        tbl.push_back(mk(B + 32'h000, 32'h0,        4'h0, 1'b1, 32'h1234cc78));
        tbl.push_back(mk(B + 32'h010, 32'h0,        4'h0, 1'b1, 32'hffffffff));
        tbl.push_back(mk(B + 32'h014, 32'h0,        4'h0, 1'b1, 32'h000000ff));
        tbl.push_back(mk(B + 32'h014, 32'h12345601, 4'h1, 1'b0, 32'h0));
        tbl.push_back(mk(B + 32'h014, 32'h0,        4'h0, 1'b1, 32'h00000001));
        tbl.push_back(mk(B + 32'h014, 32'h000000ff, 4'hf, 1'b0, 32'h0));
        tbl.push_back(mk(B + 32'h100, 32'h00000003, 4'hf, 1'b0, 32'h0));
        tbl.push_back(mk(B + 32'h100, 32'h0,        4'h0, 1'b1, 32'h00000001));
        tbl.push_back(mk(B + 32'h104, 32'h000001ff, 4'hf, 1'b0, 32'h0));
        tbl.push_back(mk(B + 32'h104, 32'h0,        4'h0, 1'b1, 32'h000000ff));
        tbl.push_back(mk(B + 32'h108, 32'h0000ff00, 4'hf, 1'b0, 32'h0));
        tbl.push_back(mk(B + 32'h108, 32'h0,        4'h0, 1'b1, 32'h00000300));
        tbl.push_back(mk(B + 32'h10c, 32'h0,        4'h0, 1'b1, 32'h0));
        tbl.push_back(mk(B + 32'h018, 32'h00000005, 4'hf, 1'b0, 32'h0));
        tbl.push_back(mk(B + 32'h018, 32'h0,        4'h0, 1'b1, 32'h0));
        tbl.push_back(mk(B + 32'h0f0, 32'h0,        4'h0, 1'b1, 32'h0));
        tbl.push_back(mk(32'h00008008, 32'h0,       4'h0, 1'b1, 32'h0));
        tbl.push_back(mk(B + 32'h000, 32'h00000011, 4'hf, 1'b1, 32'h1234cc78));
        tbl.push_back(mk(B + 32'h000, 32'h0,        4'h0, 1'b1, 32'h00000011));
        tbl.push_back(mk(B + 32'h104, 32'h0,        4'hf, 1'b0, 32'h0));
        tbl.push_back(mk(B + 32'h108, 32'h0,        4'hf, 1'b0, 32'h0));
        tbl.push_back(mk(B + 32'h108, 32'h0,        4'h0, 1'b1, 32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            op(tbl[i].adr, tbl[i].dw, tbl[i].we, tbl[i].re, rd);
            if (tbl[i].re) chk($sformatf("table[%0d] rd", i), rd, tbl[i].exp);
            else           chk($sformatf("table[%0d] idle d_dr", i), rd, 32'h0);
        end
        chk("msip set", {31'h0, msip}, 32'h1);
        wr(32'h100, 32'h0);
        chk("msip clr", {31'h0, msip}, 32'h0);

        // Prescale 3: mtime advances every 4 clocks after run is set
        wr(32'h000, 32'h0);
        wr(32'h004, 32'h0);
        wr(32'h104, 32'h3);
        wr(32'h108, 32'h1);
        for (int i = 1; i <= 12; i++) begin
            op(B, 0, 4'h0, 1'b1, rd);
            chk($sformatf("presc lo @%0d", i), rd, 32'((i - 1) / 4));
        end

        // Carry from lo into hi
        wr(32'h108, 32'h0);
        wr(32'h000, 32'hffffffff);
        wr(32'h004, 32'h0);
        wr(32'h104, 32'h0);
        wr(32'h108, 32'h1);
        op(B, 0, 4'h0, 1'b0, rd);
        op(B + 32'h004, 0, 4'h0, 1'b1, rd);
        chk("carry hi", rd, 32'h1);

        // Compare channel 0 with irq enabled, channel 1 hit but masked
        wr(32'h108, 32'h0);
        wr(32'h000, 32'd100);
        wr(32'h004, 32'h0);
        wr(32'h008, 32'd105);
        wr(32'h00c, 32'h0);
        wr(32'h010, 32'd10);
        wr(32'h014, 32'h0);
        wr(32'h108, 32'h101);
        for (int i = 1; i <= 9; i++) begin
            op(B, 0, 4'h0, 1'b0, rd);
            chk($sformatf("cmp0 hit @%0d", i), {31'h0, cmp_hit[0]}, (i >= 6) ? 32'h1 : 32'h0);
            chk($sformatf("cmp1 hit @%0d", i), {31'h0, cmp_hit[1]}, 32'h1);
            chk($sformatf("mtip @%0d", i), {31'h0, mtip}, (i >= 7) ? 32'h1 : 32'h0);
        end
        wr(32'h008, 32'd200);
        op(B, 0, 4'h0, 1'b0, rd);
        chk("ack hit0 +1", {31'h0, cmp_hit[0]}, 32'h0);
        chk("ack mtip +1", {31'h0, mtip}, 32'h1);
        op(B, 0, 4'h0, 1'b0, rd);
        chk("ack mtip +2", {31'h0, mtip}, 32'h0);
        op(B + 32'h10c, 0, 4'h0, 1'b1, rd);
        chk("status", rd, 32'h2);

        // Writes in tick cycles hold the other half; wrap at 40 bits
        wr(32'h000, 32'hfffffffe);
        wr(32'h004, 32'h000000ff);
        op(B, 0, 4'h0, 1'b1, rd);
        chk("hold lo", rd, 32'hfffffffe);
        chk("pre-wrap hits", {30'h0, cmp_hit}, 32'h3);
        op(B + 32'h004, 0, 4'h0, 1'b1, rd);
        chk("pre-wrap hi", rd, 32'h000000ff);
        op(B, 0, 4'h0, 1'b1, rd);
        chk("wrap lo", rd, 32'h0);
        op(B + 32'h004, 0, 4'h0, 1'b1, rd);
        chk("wrap hi", rd, 32'h0);
        chk("wrap hits", {30'h0, cmp_hit}, 32'h0);

        // Lo-then-hi read straddling a carry
        wr(32'h000, 32'hffffffff);
        wr(32'h004, 32'h0);
        op(B, 0, 4'h0, 1'b1, rd);
        chk("snap lo", rd, 32'hffffffff);
`ifdef RV_CLINT_SNAPSHOT_EN
        exp_hi = 32'h0;
`else
        exp_hi = 32'h1;
`endif
        op(B + 32'h004, 0, 4'h0, 1'b1, rd);
        chk("snap hi", rd, exp_hi);
        op(B + 32'h004, 0, 4'h0, 1'b1, rd);
        chk("live hi", rd, 32'h1);

        // Reset asserted during an access
        wr(32'h100, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        d_adr = B + 32'h008; d_dw = 32'h5; d_we = 4'hf; d_re = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset d_dr", d_dr, 32'h0);
        chk("midreset msip", {31'h0, msip}, 32'h0);
        chk("midreset mtip", {31'h0, mtip}, 32'h0);
        chk("midreset hits", {30'h0, cmp_hit}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        d_adr = 32'h0; d_dw = 32'h0; d_we = 4'h0; d_re = 1'b0;
        op(B + 32'h008, 0, 4'h0, 1'b1, rd);
        chk("post-reset cmp0", rd, 32'hffffffff);
        op(B + 32'h108, 0, 4'h0, 1'b1, rd);
        chk("post-reset ctrl", rd, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
